noc_switch_rr: RTL and testbench
================================

Name: noc_switch_rr

Overview:
- Parametrised successor to the fixed 5-port, 8-bit mesh switch: one router node of the on-chip mesh.
- Ports: Local, North, East, South, West.
- Each input port buffers flits in a FIFO of depth DEPTH.
- Each output port has an independent round-robin arbiter and a registered output stage with a valid/ready handshake. Backpressure propagates to upstream neighbours instead of losing data.
- Single-flit packets; each flit carries a destination port index.

Parameters:
- DW, 8: flit data width in bits.
- DEPTH, 4: input FIFO depth per port (power of 2, at least 2).
- NPORTS, 5: number of ports, max 7. Index map: 0=L, 1=N, 2=E, 3=S, 4=W.
- DESTW, 3: destination field width. Value 7 means "no request".

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  NPORTS*DW  input flits, port p at bits [p*DW +: DW].
- in_dest  in  NPORTS*DESTW  destination index per input flit.
- in_valid  in  NPORTS  flit present on input p.
- in_ready  out  NPORTS  input FIFO p can accept a flit (successor of grant_*).
- out_data  out  NPORTS*DW  output flits.
- out_valid  out  NPORTS  output register p holds a flit.
- out_ready  in  NPORTS  downstream accepts output p.
- drop_cnt  out  8  saturating count of flits with an illegal destination.

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - All FIFOs emptied.
  - out_valid=0, out_data=0, drop_cnt=0.
  - All arbiter pointers set to NPORTS-1, so port 0 has highest priority first.
  - in_ready is 0 during the reset cycle and 1 on the cycle after.
  - A reset applied mid-traffic discards all buffered and in-flight flits. No partial state survives.
- Input handshake:
  - A flit is accepted at an edge where in_valid[p] & in_ready[p] are both 1; data and dest are pushed together.
  - in_ready[p] = !full[p]. When the FIFO is full, in_ready stays 0 even if a pop occurs in the same cycle; no combinational ready-from-pop path.
- Head routing:
  - A non-empty FIFO p presents head dest d.
  - If d < NPORTS, it raises a request to output d. Loopback (d == p) is legal.
  - If d >= NPORTS, the head is popped on the next edge without forwarding, and drop_cnt increments, saturating at 255.
- Output arbitration, per output o:
  - The output is free when !out_valid[o] | out_ready[o].
  - When free, the arbiter grants the first requester found scanning from ptr[o]+1 upward, modulo NPORTS.
  - On a grant at an edge: the winner's head is popped, out_data[o] and out_valid[o] are loaded, and ptr[o] is set to the winner.
  - If the output is free but nothing is granted, out_valid[o] is cleared.
  - If the output is not free, the registered flit and ptr hold.
- One input can win at most one output per cycle (single head). Multiple outputs can be granted to different inputs in the same cycle.
- Latency:
  - Flit accepted at edge t, with its FIFO empty and its output uncontested and free: out_valid is high after edge t+1.
  - Minimum latency is 2 cycles.
  - Throughput is 1 flit/cycle per output under continuous out_ready=1.
- FIFO boundaries:
  - Pointers wrap modulo DEPTH.
  - Full/empty is tracked by a count register of width clog2(DEPTH)+1.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Ordering: flits from a single input to a single output leave in arrival order.
- Output stability: out_data is stable while out_valid=1 and out_ready=0.

Decomposition:
- Package noc_pkg:
  - Port index constants P_L=0, P_N=1, P_E=2, P_S=3, P_W=4.
  - DEST_NONE=7.
  - Default DW/DEPTH.
  - Flit struct {data, dest}.
- Sub-module noc_fifo:
  - Parameters DW+DESTW, DEPTH.
  - Ports: push/pop, full/empty.
  - Instantiated NPORTS times.
- The round-robin arbiter stays as a generate loop inside the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1.
  - Required: out_valid=0, in_ready=0 during reset, in_ready=1 after, no flit accepted during reset.
- Single flit: W sends data 0x04, dest 0 (L), out_ready=1.
  - Required: out_valid[L]=1 with out_data 0x04 exactly 2 cycles after acceptance; all other out_valid stay 0.
- Contention: L, N, E, S, W each send one flit to S in the same cycle after reset, data 1..5.
  - Required: out_data[S] sequence 1, 2, 3, 4, 5 on consecutive cycles.
  - Then a second identical burst with ptr=4 produces 1, 2, 3, 4, 5 again.
- Backpressure: out_ready[E]=0 while W streams data 5, 6, 7, … to E with DEPTH=4.
  - Required: one flit held in the output register, 4 flits fill FIFO W, in_ready[W]=0.
  - On raising out_ready[E], the flits emerge in order 5, 6, 7, … with none lost or duplicated.
- Illegal destination: N sends dest 5, then dest 6.
  - Required: no out_valid asserted, drop_cnt=2.
  - Forcing 300 illegal flits saturates drop_cnt at 255.
- Parallel paths: W→E and E→W concurrently, continuous, out_ready=1.
  - Required: both outputs sustain 1 flit/cycle with no stalls.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and flit payload for the mesh router node.
package noc_pkg;

    localparam int unsigned P_L = 0;
    localparam int unsigned P_N = 1;
    localparam int unsigned P_E = 2;
    localparam int unsigned P_S = 3;
    localparam int unsigned P_W = 4;

    localparam int unsigned NPORTS_DEF = 5;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned DESTW_DEF  = 3;

    localparam int unsigned DEST_NONE  = 7;
    localparam int unsigned DROP_W     = 8;

    // Stored FIFO word layout is {data, dest}, matching this struct.
    typedef struct packed {
        logic [DW_DEF-1:0]    data;
        logic [DESTW_DEF-1:0] dest;
    } flit_t;

endpackage

// File: rtl/noc_fifo.sv
// Per-input flit buffer: count-tracked circular FIFO with registered state.
module noc_fifo
    import noc_pkg::*;
#(
    parameter int unsigned W     = DW_DEF + DESTW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/noc_switch_rr.sv
// Mesh router node: per-input FIFOs, per-output round-robin arbiter and
// registered valid/ready output stage; illegal destinations are dropped.
module noc_switch_rr
    import noc_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned NPORTS = NPORTS_DEF,
    parameter int unsigned DESTW  = DESTW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS*DW-1:0]    in_data,
    input  logic [NPORTS*DESTW-1:0] in_dest,
    input  logic [NPORTS-1:0]       in_valid,
    output logic [NPORTS-1:0]       in_ready,
    output logic [NPORTS*DW-1:0]    out_data,
    output logic [NPORTS-1:0]       out_valid,
    input  logic [NPORTS-1:0]       out_ready,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int unsigned FW       = DW + DESTW;
    localparam int unsigned PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] empty;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] illegal;
    logic [DW-1:0]     head_data [NPORTS];
    logic [DESTW-1:0]  head_dest [NPORTS];
    logic [NPORTS-1:0] req_to    [NPORTS];
    logic [NPORTS-1:0] gnt_all   [NPORTS];
    logic              ready_en;
    logic [DROP_W-1:0] drop_nxt;
    int unsigned       drop_sum;

    // Ready is held low for the reset cycle and opens on the first idle edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign in_ready = {NPORTS{ready_en}} & ~full;
    assign push     = in_valid & in_ready;

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        logic [FW-1:0] rdata;

        noc_fifo #(
            .W     (FW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .pop   (pop[p]),
            .wdata ({in_data[p*DW +: DW], in_dest[p*DESTW +: DESTW]}),
            .rdata (rdata),
            .full  (full[p]),
            .empty (empty[p])
        );

        assign head_data[p] = rdata[FW-1:DESTW];
        assign head_dest[p] = rdata[DESTW-1:0];
    end

    // Decode each head into an output request or an illegal-destination drop.
    always_comb begin
        illegal = '0;
        for (int o = 0; o < NPORTS; o++) begin
            req_to[o] = '0;
        end
        for (int p = 0; p < NPORTS; p++) begin
            for (int o = 0; o < NPORTS; o++) begin
                req_to[o][p] = !empty[p] && (head_dest[p] == DESTW'(o));
            end
            illegal[p] = !empty[p] && (32'(head_dest[p]) >= NPORTS);
        end
    end

    // A head leaves its FIFO when granted or when it is being dropped.
    always_comb begin
        pop = illegal;
        for (int o = 0; o < NPORTS; o++) begin
            pop = pop | gnt_all[o];
        end
    end

    // Saturating sum of all drops taken this cycle.
    always_comb begin
        drop_sum = 32'(drop_cnt);
        for (int p = 0; p < NPORTS; p++) begin
            drop_sum = drop_sum + 32'(illegal[p]);
        end
        drop_nxt = (drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX) : DROP_W'(drop_sum);
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic [PW-1:0]     ptr_q;
        logic [DW-1:0]     data_q;
        logic              valid_q;
        logic              free_c;
        logic              hit_c;
        logic [PW-1:0]     win_c;
        logic [PW-1:0]     idx_c;
        logic [NPORTS-1:0] gnt_c;

        assign free_c = !valid_q || out_ready[o];

        // Round-robin search starting just after the last winner.
        always_comb begin
            gnt_c = '0;
            hit_c = 1'b0;
            win_c = ptr_q;
            idx_c = '0;
            if (free_c) begin
                for (int unsigned i = 1; i <= NPORTS; i++) begin
                    idx_c = PW'((32'(ptr_q) + i) % NPORTS);
                    if (!hit_c && req_to[o][idx_c]) begin
                        hit_c        = 1'b1;
                        win_c        = idx_c;
                        gnt_c[idx_c] = 1'b1;
                    end
                end
            end
        end

        // Output register: load on grant, clear when free and idle, else hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                ptr_q   <= PW'(NPORTS - 1);
            end else if (free_c) begin
                if (hit_c) begin
                    valid_q <= 1'b1;
                    data_q  <= head_data[win_c];
                    ptr_q   <= win_c;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign gnt_all[o]             = gnt_c;
        assign out_valid[o]           = valid_q;
        assign out_data[o*DW +: DW]   = data_q;
    end

endmodule

// File: tb/tb_noc_switch_rr.sv
// Self-checking bench for noc_switch_rr with a queue-based reference model.
module tb_noc_switch_rr;
    import noc_pkg::*;

    localparam int unsigned NP    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned DESTW = 3;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]    in_data;
    logic [NP*DESTW-1:0] in_dest;
    logic [NP-1:0]       in_valid;
    logic [NP-1:0]       in_ready;
    logic [NP*DW-1:0]    out_data;
    logic [NP-1:0]       out_valid;
    logic [NP-1:0]       out_ready;
    logic [7:0]          drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: one queue per input, output registers, pointers.
    flit_t         mq [NP][$];
    logic [NP-1:0] m_ov;
    logic [DW-1:0] m_od [NP];
    int            m_ptr [NP];
    int            m_drop;
    bit            m_en;

    noc_switch_rr #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .NPORTS (NP),
        .DESTW  (DESTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [NP*DW-1:0] exp_data();
        logic [NP*DW-1:0] v;
        for (int p = 0; p < NP; p++) v[p*DW +: DW] = m_od[p];
        return v;
    endfunction

    function automatic logic [NP-1:0] exp_rdy();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = m_en && (mq[p].size() < int'(DEPTH));
        return v;
    endfunction

    task automatic clear_inputs();
        in_valid = '0;
        in_data  = '0;
        in_dest  = '0;
    endtask

    task automatic send(input int p, input int d, input logic [DW-1:0] v);
        in_valid[p]                = 1'b1;
        in_dest[p*DESTW +: DESTW]  = DESTW'(d);
        in_data[p*DW +: DW]        = v;
    endtask

    // Advance one clock, updating the model from the switching rules.
    task automatic cycle();
        logic [NP-1:0] nov;
        logic [NP-1:0] pops;
        logic [NP-1:0] acc;
        logic [DW-1:0] nod [NP];
        int            nptr [NP];
        flit_t         nf [NP];
        int            nd;
        nov  = m_ov;
        nod  = m_od;
        nptr = m_ptr;
        pops = '0;
        acc  = '0;
        nd   = 0;
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                if (!m_ov[o] || out_ready[o]) begin
                    int win;
                    win = -1;
                    for (int k = 1; k <= NP; k++) begin
                        int c;
                        c = (m_ptr[o] + k) % NP;
                        if (win < 0 && mq[c].size() > 0 && int'(mq[c][0].dest) == o) win = c;
                    end
                    if (win >= 0) begin
                        nov[o]    = 1'b1;
                        nod[o]    = mq[win][0].data;
                        nptr[o]   = win;
                        pops[win] = 1'b1;
                    end else begin
                        nov[o] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (mq[p].size() > 0 && int'(mq[p][0].dest) >= int'(NP)) begin
                    pops[p] = 1'b1;
                    nd++;
                end
                acc[p]     = in_valid[p] && m_en && (mq[p].size() < int'(DEPTH));
                nf[p].data = in_data[p*DW +: DW];
                nf[p].dest = in_dest[p*DESTW +: DESTW];
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                m_od[p]  = '0;
                m_ptr[p] = NP - 1;
            end
            m_ov   = '0;
            m_drop = 0;
            m_en   = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (pops[p]) void'(mq[p].pop_front());
                if (acc[p]) mq[p].push_back(nf[p]);
            end
            m_ov   = nov;
            m_od   = nod;
            m_ptr  = nptr;
            m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
            m_en   = 1'b1;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = '1;
        in_valid  = '1;
        in_dest   = '0;
        in_data   = 40'h0102030405;
        repeat (2) begin
            cycle();
            n_chk++; if (out_valid !== '0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
            n_chk++; if (in_ready !== '0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
            n_chk++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else n_pass++;
            n_chk++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
        end
        rst = 1'b0;
        clear_inputs();
        cycle();
        n_chk++; if (in_ready !== 5'b11111) $display("FAIL post_reset_ready got %b want 11111", in_ready); else n_pass++;
        repeat (2) begin
            cycle();
            n_chk++; if (out_valid !== '0) $display("FAIL reset_no_accept got %b want 0", out_valid); else n_pass++;
        end
    endtask

    task automatic test_single();
        out_ready = '1;
        send(P_W, P_L, 8'h04);
        cycle();
        clear_inputs();
        n_chk++; if (out_valid !== '0) $display("FAIL single_early got %b want 0", out_valid); else n_pass++;
        cycle();
        n_chk++; if (out_valid !== 5'b00001) $display("FAIL single_valid got %b want 00001", out_valid); else n_pass++;
        n_chk++; if (out_data[P_L*DW +: DW] !== 8'h04) $display("FAIL single_data got %h want 04", out_data[P_L*DW +: DW]); else n_pass++;
        cycle();
        n_chk++; if (out_valid !== '0) $display("FAIL single_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_contention();
        do_reset();
        out_ready = '1;
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < NP; p++) send(p, P_S, DW'(p + 1));
            cycle();
            clear_inputs();
            for (int k = 1; k <= 5; k++) begin
                cycle();
                n_chk++;
                if (out_valid !== 5'b01000 || out_data[P_S*DW +: DW] !== DW'(k))
                    $display("FAIL contention_b%0d_k%0d got v=%b d=%0d want v=01000 d=%0d", b, k, out_valid, out_data[P_S*DW +: DW], k);
                else n_pass++;
            end
            cycle();
            n_chk++; if (out_valid !== '0) $display("FAIL contention_drain got %b want 0", out_valid); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        logic [DW-1:0] got [$];
        int            n_acc;
        logic          rdy;
        do_reset();
        out_ready      = '1;
        out_ready[P_E] = 1'b0;
        d     = 8'd5;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            send(P_W, P_E, d);
            rdy = in_ready[P_W];
            cycle();
            if (rdy) begin
                d++;
                n_acc++;
            end
        end
        clear_inputs();
        n_chk++; if (n_acc != 5) $display("FAIL bp_accepted got %0d want 5", n_acc); else n_pass++;
        n_chk++; if (in_ready[P_W] !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready[P_W]); else n_pass++;
        n_chk++;
        if (out_valid[P_E] !== 1'b1 || out_data[P_E*DW +: DW] !== 8'd5)
            $display("FAIL bp_hold got v=%b d=%0d want v=1 d=5", out_valid[P_E], out_data[P_E*DW +: DW]);
        else n_pass++;
        out_ready[P_E] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid[P_E] === 1'b1) got.push_back(out_data[P_E*DW +: DW]);
            cycle();
        end
        n_chk++; if (got.size() != 5) $display("FAIL bp_count got %0d want 5", got.size()); else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_chk++; if (got[i] !== DW'(5 + i)) $display("FAIL bp_order_%0d got %0d want %0d", i, got[i], 5 + i); else n_pass++;
        end
    endtask

    task automatic test_illegal();
        int   sent;
        logic rdy;
        do_reset();
        out_ready = '1;
        send(P_N, 5, 8'hA5);
        cycle();
        send(P_N, 6, 8'h5A);
        cycle();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_chk++; if (out_valid !== '0) $display("FAIL illegal_valid got %b want 0", out_valid); else n_pass++;
        end
        n_chk++; if (drop_cnt !== 8'd2) $display("FAIL illegal_drop2 got %0d want 2", drop_cnt); else n_pass++;
        sent = 0;
        for (int c = 0; c < 500 && sent < 300; c++) begin
            send(P_N, 5 + int'($urandom_range(0, 2)), DW'($urandom));
            rdy = in_ready[P_N];
            cycle();
            if (rdy) sent++;
        end
        clear_inputs();
        repeat (6) cycle();
        n_chk++; if (sent != 300) $display("FAIL illegal_sent got %0d want 300", sent); else n_pass++;
        n_chk++; if (drop_cnt !== 8'd255) $display("FAIL illegal_sat got %0d want 255", drop_cnt); else n_pass++;
        n_chk++; if (out_valid !== '0) $display("FAIL illegal_end_valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_parallel();
        logic [DW-1:0] de, dw, ee, ew;
        do_reset();
        out_ready = '1;
        de = 8'h10; dw = 8'h80; ee = 8'h10; ew = 8'h80;
        for (int c = 0; c < 30; c++) begin
            send(P_W, P_E, de);
            send(P_E, P_W, dw);
            cycle();
            de++;
            dw++;
            if (c >= 1) begin
                n_chk++;
                if (out_valid[P_E] !== 1'b1 || out_valid[P_W] !== 1'b1 ||
                    out_data[P_E*DW +: DW] !== ee || out_data[P_W*DW +: DW] !== ew)
                    $display("FAIL parallel_c%0d got E=%b/%h W=%b/%h want 1/%h 1/%h", c,
                             out_valid[P_E], out_data[P_E*DW +: DW], out_valid[P_W], out_data[P_W*DW +: DW], ee, ew);
                else n_pass++;
                ee++;
                ew++;
            end
        end
        clear_inputs();
        n_chk++; if (in_ready !== 5'b11111) $display("FAIL parallel_ready got %b want 11111", in_ready); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < NP; p++) begin
                in_valid[p]   = ($urandom_range(0, 2) != 0);
                out_ready[p]  = ($urandom_range(0, 3) != 0);
                in_data[p*DW +: DW] = DW'($urandom);
                if ($urandom_range(0, 7) == 0)
                    in_dest[p*DESTW +: DESTW] = DESTW'(5 + $urandom_range(0, 2));
                else
                    in_dest[p*DESTW +: DESTW] = DESTW'($urandom_range(0, NP - 1));
            end
            cycle();
            n_chk++; if (out_valid !== m_ov) $display("FAIL rand_valid c=%0d got %b want %b", c, out_valid, m_ov); else n_pass++;
            n_chk++; if (out_data !== exp_data()) $display("FAIL rand_data c=%0d got %h want %h", c, out_data, exp_data()); else n_pass++;
            n_chk++; if (in_ready !== exp_rdy()) $display("FAIL rand_ready c=%0d got %b want %b", c, in_ready, exp_rdy()); else n_pass++;
            n_chk++; if (int'(drop_cnt) != m_drop) $display("FAIL rand_drop c=%0d got %0d want %0d", c, drop_cnt, m_drop); else n_pass++;
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = '1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_parallel();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
